// File: rtl/ir_enc.sv
// ir_enc: instruction encoder / program writer for the t5 accumulator CPU.
// Packs decoded (op, ad) pairs into 8-bit instruction words.
// Writes them sequentially into program memory starting at BASE.
// Optional: define IR_ENC_CSUM_EN to add an 8-bit running checksum output (csum).

// Instruction class codes shared with the decoder (k = op[7:5]).
`ifndef CU_ADD
`define CU_ADD        3'b000
`endif
`ifndef CU_STA
`define CU_STA        3'b001
`endif
`ifndef CU_LDA
`define CU_LDA        3'b010
`endif
`ifndef CU_JMP
`define CU_JMP        3'b011
`endif
`ifndef CU_BAN
`define CU_BAN        3'b100
`endif
`ifndef CU_LONG_BEGIN
`define CU_LONG_BEGIN 3'b111
`endif

module ir_enc #(
  parameter int ADDR_W = 5,
  parameter int BASE   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [7:0]        in_op,
  input  logic [7:0]        in_ad,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              full,
  output logic              err,
  output logic [ADDR_W:0]   count
`ifdef IR_ENC_CSUM_EN
  ,
  output logic [7:0]        csum
`endif
);

  localparam logic [ADDR_W-1:0] TOP    = '1;
  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE);

  typedef enum logic [1:0] {IDLE, RUN, FULL} state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;      // next address to be written
  logic [2:0]        k;
  logic              is_short;
  logic              is_long;
  logic              legal;
  logic [7:0]        enc;
  logic              accept;

  // Classify the incoming pair and build its instruction word.
  always_comb begin
    k        = in_op[7:5];
    is_short = (k == `CU_ADD) || (k == `CU_STA) || (k == `CU_LDA) ||
               (k == `CU_JMP) || (k == `CU_BAN);
    is_long  = (k == `CU_LONG_BEGIN);
    legal    = (is_short && (in_op[4:0] == 5'd0) && (in_ad[7:5] == 3'd0)) ||
               (is_long && (in_ad == 8'd0));
    enc      = is_short ? {k, in_ad[4:0]} : in_op;
    accept   = in_valid && in_ready;
  end

  // Control FSM with registered write port and status outputs.
  // A legal accept loads the output register; reaching TOP locks into FULL.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state    <= IDLE;
      ptr      <= BASE_A;
      in_ready <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= BASE_A;
      wr_data  <= 8'd0;
      full     <= 1'b0;
      err      <= 1'b0;
      count    <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE, RUN: begin
          in_ready <= 1'b1;
          wr_addr  <= ptr;
          if (accept) begin
            state <= RUN;
            if (legal) begin
              wr_en   <= 1'b1;
              wr_data <= enc;
              count   <= count + (ADDR_W+1)'(1);
              if (ptr == TOP) begin
                // last slot: stop accepting from the very cycle it is written
                state    <= FULL;
                full     <= 1'b1;
                in_ready <= 1'b0;
              end else begin
                ptr <= ptr + ADDR_W'(1);
              end
            end else begin
              err <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          in_ready <= 1'b0;
          full     <= 1'b1;
        end
      endcase
    end
  end

`ifdef IR_ENC_CSUM_EN
  // Running modulo-256 sum of issued words, one cycle behind the write.
  always_ff @(posedge clk) begin
    if (rst || clr)
      csum <= 8'd0;
    else if (wr_en)
      csum <= csum + wr_data;
  end
`endif

endmodule
